icache: RTL and testbench



---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 131 +++++++++++++
 tb/tb_icache.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Valid/ready: a fetch is served in any cycle with imemREN && ihit; a memory beat completes in any cycle with iREN && !iwait.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a two-beat block refill.
// Optional hit/miss statistics counters are enabled with `define ICACHE_STATS_EN.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    icache_if.slave     bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [1:0]  state_dbg_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL0 = 2'd1, FILL1 = 2'd2} state_t;

    state_t             state_q;
    logic [TAG_W-1:0]   ltag_q;
    logic [IDX_W-1:0]   lidx_q;
    logic [31:0]        word0_q;
    logic               iren_q;
    logic [31:0]        iaddr_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q [SETS];
    logic [31:0]        w0_q  [SETS];
    logic [31:0]        w1_q  [SETS];

    logic [IDX_W-1:0]   addr_idx;
    logic [TAG_W-1:0]   addr_tag;
    logic               addr_blk;
    logic               lookup_hit;
    logic               miss_start;
    logic               fill_done;

    assign addr_idx   = bus.imemaddr[IDX_W+2:3];
    assign addr_tag   = bus.imemaddr[31:IDX_W+3];
    assign addr_blk   = bus.imemaddr[2];
    assign lookup_hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

    assign bus.ihit     = (state_q == IDLE) && bus.imemREN && lookup_hit && !flush;
    assign bus.imemload = addr_blk ? w1_q[addr_idx] : w0_q[addr_idx];
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = iaddr_q;
    assign state_dbg_o  = state_q;

    // flush beats a completing fill, so a frame is only written when neither reset nor flush is active.
    assign miss_start = (state_q == IDLE) && bus.imemREN && !lookup_hit && !flush;
    assign fill_done  = (state_q == FILL1) && !bus.iwait && !flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            valid_q <= '0;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            valid_q <= '0;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_start) begin
                        ltag_q  <= addr_tag;
                        lidx_q  <= addr_idx;
                        state_q <= FILL0;
                        iren_q  <= 1'b1;
                        iaddr_q <= {addr_tag, addr_idx, 3'b000};
                    end
                end
                FILL0: begin
                    if (!bus.iwait) begin
                        word0_q <= bus.iload;
                        state_q <= FILL1;
                        iaddr_q <= {ltag_q, lidx_q, 3'b100};
                    end
                end
                FILL1: begin
                    if (!bus.iwait) begin
                        valid_q[lidx_q] <= 1'b1;
                        state_q         <= IDLE;
                        iren_q          <= 1'b0;
                        iaddr_q         <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    iren_q  <= 1'b0;
                    iaddr_q <= '0;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid_q alone decides whether they mean anything.
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            tag_q[lidx_q] <= ltag_q;
            w0_q[lidx_q]  <= word0_q;
            w1_q[lidx_q]  <= bus.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign hit_cnt_d  = hit_cnt_q + (bus.ihit ? 32'd1 : 32'd0);
    assign miss_cnt_d = miss_cnt_q + ((miss_start && !RST) ? 32'd1 : 32'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for icache: fetch vectors plus hand-built redirect, flush and reset sequences.
module tb_icache;
  logic        CLK;
  logic        RST;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

`ifdef ICACHE_STATS_EN
  localparam logic [31:0] EXP_HITS   = 32'd6;
  localparam logic [31:0] EXP_MISSES = 32'd1;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  icache_if bus ();

  icache #(.SETS(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .bus         (bus),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // memory model: two words pinned by the cold-miss scenario, a recognisable pattern elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hAAAA_0001;
    if (a == 32'h0000_0044) return 32'hAAAA_0002;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.iload = mem_word(bus.iaddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Fetch addr until ihit; iwait held high for 'waits' cycles at the start of each beat.
  task automatic fetch(input string name, input logic [31:0] addr, input int waits,
                       input logic [31:0] exp_data, input int exp_stall);
    int   stall;
    int   low;
    int   wc;
    logic beat;
    logic seq_ok;
    logic got;
    logic [31:0] want_addr;
    bus.imemaddr = addr;
    bus.imemREN  = 1'b1;
    bus.iwait    = 1'b0;
    stall = 0; low = 0; wc = 0; beat = 1'b0; seq_ok = 1'b1; got = 1'b0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      #1;
      if (bus.ihit) begin
        got = 1'b1;
      end else begin
        low++;
        if (bus.iREN) begin
          stall++;
          want_addr = {addr[31:3], beat, 2'b00};
          if (bus.iaddr !== want_addr) seq_ok = 1'b0;
          if (wc < waits) begin
            bus.iwait = 1'b1;
            wc++;
          end else begin
            bus.iwait = 1'b0;
            wc = 0;
            beat = ~beat;
          end
        end else begin
          bus.iwait = 1'b0;
        end
        @(negedge CLK);
      end
    end
    bus.iwait = 1'b0;
    check({name, "_ihit_seen"}, {31'd0, got}, 32'd1);
    check({name, "_data"}, bus.imemload, exp_data);
    check({name, "_iren_cycles"}, stall, exp_stall);
    check({name, "_low_cycles"}, low, (exp_stall == 0) ? 0 : exp_stall + 1);
    check({name, "_iaddr_seq"}, {31'd0, seq_ok}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          waits;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // idx = addr[6:3], tag = addr[31:7]
    vecs[0] = '{32'h0000_0040, 0, 32'hAAAA_0001, 2};  // cold miss
    vecs[1] = '{32'h0000_0044, 0, 32'hAAAA_0002, 0};  // other word of the block
    vecs[2] = '{32'h0000_0040, 0, 32'hAAAA_0001, 0};
    vecs[3] = '{32'h0000_1040, 3, 32'hC0DE_1040, 8};  // wait states, evicts idx 8
    vecs[4] = '{32'h0000_1044, 0, 32'hC0DE_1044, 0};
    vecs[5] = '{32'h0000_0040, 1, 32'hAAAA_0001, 4};  // evicted, refills
    vecs[6] = '{32'h0000_0000, 0, 32'hC0DE_0000, 2};
    vecs[7] = '{32'h0000_0080, 2, 32'hC0DE_0080, 6};  // conflict on idx 0
    vecs[8] = '{32'h0000_0000, 0, 32'hC0DE_0000, 2};  // misses again after eviction
    vecs[9] = '{32'h0000_0040, 0, 32'hAAAA_0001, 0};  // idx 8 untouched

    RST = 1'b1; flush = 1'b0;
    bus.imemREN = 1'b0; bus.imemaddr = 32'h0; bus.iwait = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    check("rst_iren", {31'd0, bus.iREN}, 32'd0);
    check("rst_iaddr", bus.iaddr, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0040;
    #1;
    check("rst_invalid", {31'd0, bus.ihit}, 32'd0);
    bus.imemREN = 1'b0;
    @(negedge CLK);
    check("ren_low_idle", {30'd0, state_dbg}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].waits, vecs[i].exp_data, vecs[i].exp_stall);
    end

    bus.imemREN = 1'b0;
    #1;
    check("ren_low_no_hit", {31'd0, bus.ihit}, 32'd0);
    @(negedge CLK);

    // Redirect during FILL0: the original block still lands in its frame.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0100;
    #1;
    check("redir_miss", {31'd0, bus.ihit}, 32'd0);
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0200;
    #1;
    check("redir_fill0_iren", {31'd0, bus.iREN}, 32'd1);
    check("redir_fill0_iaddr", bus.iaddr, 32'h0000_0100);
    @(negedge CLK);
    #1;
    check("redir_fill1_iaddr", bus.iaddr, 32'h0000_0104);
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0100;
    #1;
    check("redir_old_hit", {31'd0, bus.ihit}, 32'd1);
    check("redir_old_data", bus.imemload, 32'hC0DE_0100);
    bus.imemaddr = 32'h0000_0200;
    #1;
    check("redir_new_miss", {31'd0, bus.ihit}, 32'd0);
    fetch("redir_new", 32'h0000_0200, 0, 32'hC0DE_0200, 2);

    // Flush at the FILL1 completion edge: no frame write, back to IDLE.
    bus.imemaddr = 32'h0000_0300;
    #1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("flush_in_fill1", {30'd0, state_dbg}, 32'd2);
    flush = 1'b1;
    #1;
    check("flush_fill_ihit", {31'd0, bus.ihit}, 32'd0);
    @(negedge CLK);
    flush = 1'b0;
    #1;
    check("flush_state_idle", {30'd0, state_dbg}, 32'd0);
    check("flush_iren", {31'd0, bus.iREN}, 32'd0);
    fetch("flush_refetch", 32'h0000_0300, 0, 32'hC0DE_0300, 2);

    // Flush while hitting: ihit forced low, every frame invalidated.
    flush = 1'b1;
    #1;
    check("flush_forces_ihit", {31'd0, bus.ihit}, 32'd0);
    @(negedge CLK);
    flush = 1'b0;
    fetch("post_flush_300", 32'h0000_0300, 0, 32'hC0DE_0300, 2);
    fetch("post_flush_40", 32'h0000_0040, 0, 32'hAAAA_0001, 2);

    // Reset mid-fill: no frame write, counters cleared.
    bus.imemaddr = 32'h0000_0500;
    #1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    check("rstmid_state", {30'd0, state_dbg}, 32'd0);
    check("rstmid_iren", {31'd0, bus.iREN}, 32'd0);
    check("rstmid_iaddr", bus.iaddr, 32'd0);
    check("rstmid_hits", hit_count, 32'd0);
    check("rstmid_misses", miss_count, 32'd0);

    // Stats: one cold miss, then the completion hit plus five more hit cycles.
    fetch("stats_miss", 32'h0000_0500, 0, 32'hC0DE_0500, 2);
    repeat (6) @(negedge CLK);
    bus.imemREN = 1'b0;
    #1;
    check("stats_hits", hit_count, EXP_HITS);
    check("stats_misses", miss_count, EXP_MISSES);
    @(negedge CLK);
    #1;
    check("stats_hits_hold", hit_count, EXP_HITS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
